// File: rtl/dmic_stereo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmic_stereo_ctrl_pkg
// Description : Shared types and constants for the stereo DMIC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================

package dmic_stereo_ctrl_pkg;

    localparam int PCM_W = 16;
    localparam int OVR_W = 8;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } dmic_state_e;

    // Adds 0..2 overrun events to the counter, pinning at all-ones.
    function automatic logic [OVR_W-1:0] ovr_sat_add(
        input logic [OVR_W-1:0] cnt,
        input logic [1:0]       inc
    );
        logic [OVR_W:0] sum;
        sum = {1'b0, cnt} + {{(OVR_W-1){1'b0}}, inc};
        return sum[OVR_W] ? {OVR_W{1'b1}} : sum[OVR_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmic_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : dmic_clk_div
// Description : PDM bit-clock divider; low for the first half period after
//               enable, then a 50% duty square wave of CLK_DIV clk cycles.
// Revision    : 1.0 - initial release
// ============================================================================

module dmic_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic mic_clk
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    assign cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            mic_clk <= 1'b0;
        end else if (clr) begin
            cnt     <= '0;
            mic_clk <= 1'b0;
        end else if (en) begin
            cnt     <= cnt_nxt;
            mic_clk <= (cnt_nxt >= HALF);
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmic_stereo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmic_stereo_ctrl
// Description : Stereo PDM mic sequencer: bit clock, settle/mute phase and a
//               two-slot L/R buffer drained as one ready/valid stream.
//               Build option DMIC_STEREO_CTRL_MONO_EN removes the R path.
// Revision    : 1.0 - initial release
// ============================================================================

module dmic_stereo_ctrl
    import dmic_stereo_ctrl_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int SETTLE   = 256,
    parameter int DEC_LOG2 = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             mic_clk,
    input  logic             l_valid,
    input  logic [PCM_W-1:0] l_pcm,
    input  logic             r_valid,
    input  logic [PCM_W-1:0] r_pcm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PCM_W-1:0] out_data,
    output logic             out_ch,
    output logic             running,
    output logic             overrun,
    output logic [OVR_W-1:0] ovr_cnt
);

    localparam logic [1:0]  S_OFF      = ST_OFF;
    localparam logic [1:0]  S_SETTLE   = ST_SETTLE;
    localparam logic [1:0]  S_RUN      = ST_RUN;
    localparam logic [15:0] SETTLE_TGT = 16'(SETTLE);

    logic [1:0]       state;
    logic [15:0]      settle_cnt;
    logic             run;
    logic             div_en;
    logic             div_clr;

    logic             l_full;
    logic             r_full;
    logic [PCM_W-1:0] l_slot;
    logic [PCM_W-1:0] r_slot;

    logic             r_strobe;
    logic [PCM_W-1:0] r_in;
    logic             cap_l;
    logic             cap_r;
    logic             xfer;
    logic             drain_l;
    logic             drain_r;
    logic             ovr_l;
    logic             ovr_r;
    logic [1:0]       ovr_inc;

    logic [DEC_LOG2-1:0] l_gap;
    logic                l_seen;

    // ------------------------------------------------------------------
    // Sequencer: en low always wins and returns to OFF on the next edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_OFF;
            settle_cnt <= '0;
        end else if (!en) begin
            state      <= S_OFF;
            settle_cnt <= '0;
        end else begin
            case (state)
                S_OFF: begin
                    state      <= S_SETTLE;
                    settle_cnt <= '0;
                end
                S_SETTLE: begin
                    // The frame that completes the count is itself discarded.
                    if (l_valid) begin
                        if (settle_cnt == SETTLE_TGT) begin
                            state <= S_RUN;
                        end else begin
                            settle_cnt <= settle_cnt + 16'd1;
                        end
                    end
                end
                S_RUN: begin
                    state <= S_RUN;
                end
                default: begin
                    state      <= S_OFF;
                    settle_cnt <= '0;
                end
            endcase
        end
    end

    assign run     = (state == S_RUN);
    assign running = run;

    assign div_en  = en & (state != S_OFF);
    assign div_clr = ~div_en;

    dmic_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (div_en),
        .clr     (div_clr),
        .mic_clk (mic_clk)
    );

    // ------------------------------------------------------------------
    // Right-channel source selection
    // ------------------------------------------------------------------
`ifdef DMIC_STEREO_CTRL_MONO_EN
    logic unused_r;
    assign unused_r = ^{r_valid, r_pcm};
    assign r_strobe = 1'b0;
    assign r_in     = '0;
`else
    assign r_strobe = r_valid;
    assign r_in     = r_pcm;
`endif

    // ------------------------------------------------------------------
    // Two-slot buffer, left has priority on the output.
    // ------------------------------------------------------------------
    assign out_valid = l_full | r_full;
    assign out_ch    = ~l_full & r_full;
    assign out_data  = l_full ? l_slot : r_slot;

    assign xfer    = out_valid & out_ready;
    assign drain_l = xfer & l_full;
    assign drain_r = xfer & ~l_full & r_full;

    assign cap_l   = run & l_valid;
    assign cap_r   = run & r_strobe;

    // Reloading a slot that is being accepted in the same cycle is lossless.
    assign ovr_l   = cap_l & l_full & ~drain_l;
    assign ovr_r   = cap_r & r_full & ~drain_r;
    assign ovr_inc = {1'b0, ovr_l} + {1'b0, ovr_r};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_full  <= 1'b0;
            r_full  <= 1'b0;
            l_slot  <= '0;
            r_slot  <= '0;
            overrun <= 1'b0;
            ovr_cnt <= '0;
        end else if (!en) begin
            l_full  <= 1'b0;
            r_full  <= 1'b0;
            overrun <= 1'b0;
            ovr_cnt <= '0;
        end else begin
            if (cap_l) begin
                l_slot <= l_pcm;
                l_full <= 1'b1;
            end else if (drain_l) begin
                l_full <= 1'b0;
            end

            if (cap_r) begin
                r_slot <= r_in;
                r_full <= 1'b1;
            end else if (drain_r) begin
                r_full <= 1'b0;
            end

            if (ovr_l | ovr_r) begin
                overrun <= 1'b1;
            end
            ovr_cnt <= ovr_sat_add(ovr_cnt, ovr_inc);
        end
    end

    // ------------------------------------------------------------------
    // Frame-gap check: left strobes must be at least one frame apart.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_gap  <= '0;
            l_seen <= 1'b0;
        end else if (l_valid) begin
            l_gap  <= '0;
            l_seen <= 1'b1;
        end else if (l_gap != {DEC_LOG2{1'b1}}) begin
            l_gap  <= l_gap + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && l_valid && l_seen) begin
            assert (l_gap == {DEC_LOG2{1'b1}});
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmic_stereo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmic_stereo_ctrl
// Description : Self-checking bench for dmic_stereo_ctrl with a cycle-level
//               behavioural model and directed + randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_dmic_stereo_ctrl;

    localparam int CLK_DIV  = 4;
    localparam int SETTLE_N = 4;
    localparam int DEC_LOG2 = 6;
    localparam int FRAME    = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        l_valid = 1'b0;
    logic        r_valid = 1'b0;
    logic [15:0] l_pcm = '0;
    logic [15:0] r_pcm = '0;
    logic        out_ready = 1'b0;
    logic        mic_clk;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ch;
    logic        running;
    logic        overrun;
    logic [7:0]  ovr_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmic_stereo_ctrl #(
        .CLK_DIV  (CLK_DIV),
        .SETTLE   (SETTLE_N),
        .DEC_LOG2 (DEC_LOG2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mic_clk   (mic_clk),
        .l_valid   (l_valid),
        .l_pcm     (l_pcm),
        .r_valid   (r_valid),
        .r_pcm     (r_pcm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .running   (running),
        .overrun   (overrun),
        .ovr_cnt   (ovr_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: mode 0=off 1=settle 2=run, slot 0=L 1=R.
    // ------------------------------------------------------------------
    int          m_mode;
    int          m_frames;
    int          m_t;
    int          m_cnt;
    bit          m_ovr;
    bit          m_full [2];
    logic [15:0] m_data [2];

    always @(posedge clk or negedge rst_n) begin : mdl
        int          old_mode;
        int          drain;
        bit          stb [2];
        logic [15:0] pcm [2];
        if (!rst_n) begin
            m_mode = 0; m_frames = 0; m_t = 0; m_cnt = 0; m_ovr = 0;
            m_full[0] = 0; m_full[1] = 0; m_data[0] = '0; m_data[1] = '0;
        end else begin
            old_mode = m_mode;
            drain = -1;
            if (out_ready) begin
                if (m_full[0]) drain = 0;
                else if (m_full[1]) drain = 1;
            end
            stb[0] = l_valid; pcm[0] = l_pcm;
`ifdef DMIC_STEREO_CTRL_MONO_EN
            stb[1] = 0; pcm[1] = '0;
`else
            stb[1] = r_valid; pcm[1] = r_pcm;
`endif
            if (!en) begin
                m_mode = 0; m_frames = 0; m_t = 0; m_cnt = 0; m_ovr = 0;
                m_full[0] = 0; m_full[1] = 0;
            end else begin
                for (int ch = 0; ch < 2; ch++) begin
                    if (old_mode == 2 && stb[ch]) begin
                        if (m_full[ch] && drain != ch) begin
                            m_ovr = 1;
                            if (m_cnt < 255) m_cnt++;
                        end
                        m_full[ch] = 1;
                        m_data[ch] = pcm[ch];
                    end else if (drain == ch) begin
                        m_full[ch] = 0;
                    end
                end
                case (old_mode)
                    0: begin m_mode = 1; m_t = 0; m_frames = 0; end
                    1: begin
                        m_t++;
                        if (l_valid) begin
                            m_frames++;
                            if (m_frames == SETTLE_N + 1) m_mode = 2;
                        end
                    end
                    default: m_t++;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("mic_clk", 32'(mic_clk),
                32'((m_mode != 0) && ((m_t % CLK_DIV) >= CLK_DIV / 2)));
            chk("out_valid", 32'(out_valid), 32'(m_full[0] | m_full[1]));
            chk("running", 32'(running), 32'(m_mode == 2));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("ovr_cnt", 32'(ovr_cnt), 32'(m_cnt));
            if (m_full[0] | m_full[1]) begin
                chk("out_data", 32'(out_data), 32'(m_full[0] ? m_data[0] : m_data[1]));
                chk("out_ch", 32'(out_ch), 32'(!m_full[0]));
            end
        end
    end

    // ------------------------------------------------------------------
    // Decimator-like strobe generator, advanced one cycle per step().
    // ------------------------------------------------------------------
    int          pos = 20;
    int          r_skew = 0;
    int          next_skew = 0;
    int          l_issued = 0;
    bit          rand_pcm = 0;
    bit          rand_ready = 0;
    int          ready_pct = 50;
    logic [15:0] l_next = '0;
    logic [15:0] r_next = '0;

    task automatic step();
        @(negedge clk);
        pos = (pos + 1) % FRAME;
        if (pos == 0) begin
            r_skew = next_skew;
            if (rand_pcm) begin
                l_pcm = 16'($urandom);
                r_pcm = 16'($urandom);
            end else begin
                l_pcm = l_next;
                r_pcm = r_next;
            end
        end
        l_valid = (pos == 0);
        r_valid = (pos == r_skew);
        if (l_valid) l_issued++;
        if (rand_ready) out_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic wait_pos(input int p);
        do step(); while (pos != p);
    endtask

    task automatic settle_and_check(input string tag);
        int base;
        bit got;
        base = l_issued;
        got  = 0;
        for (int i = 0; i < 8 * FRAME; i++) begin
            step();
            if (running) begin
                got = 1;
                break;
            end
        end
        chk({tag, "_reached"}, 32'(got), 32'd1);
        chk({tag, "_frames"}, 32'(l_issued - int'(l_valid) - base), 32'(SETTLE_N + 1));
    endtask

    initial begin : stim
        int  hi;
        bit  got;
        #1;
        chk("rst_mic_clk", 32'(mic_clk), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_ovr_cnt", 32'(ovr_cnt), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        hi = 0;
        repeat (100) begin
            step();
            if (mic_clk) hi++;
        end
        chk("mic_low_100", 32'(hi), 32'd0);

        // Settle: 5 frames discarded, then an L/R pair on consecutive cycles.
        out_ready = 1'b1;
        en = 1'b1;
        settle_and_check("settle");
        l_next = 16'h1234;
        r_next = 16'hFEDC;
        got = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (out_valid) begin
                got = 1;
                break;
            end
        end
        chk("pair_valid", 32'(got), 32'd1);
        chk("pair_l_data", 32'(out_data), 32'h1234);
        chk("pair_l_ch", 32'(out_ch), 32'd0);
        step();
`ifndef DMIC_STEREO_CTRL_MONO_EN
        chk("pair_r_data", 32'(out_data), 32'hFEDC);
        chk("pair_r_ch", 32'(out_ch), 32'd1);
        step();
`endif
        chk("pair_drained", 32'(out_valid), 32'd0);

        // Two frames with no drain: second frame overwrites both slots.
        out_ready = 1'b0;
        l_next = 16'h1111; r_next = 16'h2222;
        wait_pos(1);
        l_next = 16'h3333; r_next = 16'h4444;
        wait_pos(1);
        chk("ovr_l_data", 32'(out_data), 32'h3333);
        chk("ovr_flag", 32'(overrun), 32'd1);
`ifndef DMIC_STEREO_CTRL_MONO_EN
        chk("ovr_cnt2", 32'(ovr_cnt), 32'd2);
        out_ready = 1'b1;
        step();
        chk("ovr_r_data", 32'(out_data), 32'h4444);
        out_ready = 1'b0;
`else
        chk("ovr_cnt1", 32'(ovr_cnt), 32'd1);
`endif
        rand_pcm = 1;
        repeat (300) wait_pos(1);
        chk("ovr_sat", 32'(ovr_cnt), 32'd255);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // en drop with a pending unaccepted sample.
        chk("drop_pre_valid", 32'(out_valid), 32'd1);
        en = 1'b0;
        step();
        chk("drop_valid", 32'(out_valid), 32'd0);
        chk("drop_mic", 32'(mic_clk), 32'd0);
        chk("drop_overrun", 32'(overrun), 32'd0);
        chk("drop_ovr_cnt", 32'(ovr_cnt), 32'd0);
        repeat (5) step();
        en = 1'b1;
        settle_and_check("resettle");

        // Drain and reload of the L slot in the same cycle.
        out_ready = 1'b1;
        next_skew = 32;
        wait_pos(63);
        out_ready = 1'b0;
        wait_pos(63);
        rand_pcm = 0;
        l_next = 16'h5A5A; r_next = 16'hA5A5;
        out_ready = 1'b1;
        step();
        step();
        chk("reload_valid", 32'(out_valid), 32'd1);
        chk("reload_data", 32'(out_data), 32'h5A5A);
        chk("reload_ch", 32'(out_ch), 32'd0);
        chk("reload_overrun", 32'(overrun), 32'd0);

        // Randomized traffic, skew, backpressure and occasional power cycles.
        rand_pcm = 1;
        rand_ready = 1;
        for (int f = 0; f < 60; f++) begin
            case ($urandom_range(0, 3))
                0: ready_pct = 5;
                1: ready_pct = 30;
                2: ready_pct = 70;
                default: ready_pct = 100;
            endcase
            next_skew = $urandom_range(0, 40);
            if ($urandom_range(0, 9) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 5)) step();
                en = 1'b1;
            end
            wait_pos(0);
        end
        rand_ready = 0;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
